// File: rtl/seq_magnitude_comparator_pkg.sv
// rtl/seq_magnitude_comparator_pkg.sv - shared types and parameter checks for the sequential comparator
package seq_magnitude_comparator_pkg;

  // Controller states: waiting for a request, or walking chunks MS first
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cmpState_e;

  // Legal geometry: non-empty operand, non-empty chunk, chunks tile the operand exactly
  function automatic bit chunkWidthOk(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // Chunk index counter width, never narrower than one bit
  function automatic int idxWidth(input int nChunk);
    return (nChunk > 1) ? $clog2(nChunk) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// rtl/seq_magnitude_comparator_chunk_compare.sv - combinational unsigned compare of one chunk
module chunk_compare #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  // Exactly one flag is set for any pair of operands
  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle magnitude comparator, one chunk per clock, early exit
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic             XlessthanY,
  output logic             XequalY,
  output logic             XgreaterthanY
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idxWidth(NCHUNK);
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NCHUNK - 1);

  if (!chunkWidthOk(WIDTH, CHUNK)) begin : gBadGeometry
    $error("seq_magnitude_comparator: CHUNK must be >= 1 and divide WIDTH exactly");
  end

  cmpState_e        state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] xReg;
  logic [WIDTH-1:0] yReg;
  logic [WIDTH-1:0] signMask;
  logic [CHUNK-1:0] xChunk;
  logic [CHUNK-1:0] yChunk;
  logic             chunkLt;
  logic             chunkEq;
  logic             chunkGt;
  logic             lastChunk;

  // Flipping the MSB maps two's-complement order onto unsigned order
  always_comb begin
    signMask = '0;
    signMask[WIDTH-1] = signed_mode;
  end

  // Operands are shifted left after each equal chunk, so the active chunk is always the top one
  always_comb begin
    xChunk    = xReg[WIDTH-1 -: CHUNK];
    yChunk    = yReg[WIDTH-1 -: CHUNK];
    lastChunk = (idx == LastIdx);
  end

  chunk_compare #(
    .W(CHUNK)
  ) uChunkCompare (
    .a (xChunk),
    .b (yChunk),
    .lt(chunkLt),
    .eq(chunkEq),
    .gt(chunkGt)
  );

  // Controller: latch on start, step chunks, finish on first difference or after the last chunk
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      xReg          <= '0;
      yReg          <= '0;
      done          <= 1'b0;
      XlessthanY    <= 1'b0;
      XequalY       <= 1'b0;
      XgreaterthanY <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xReg  <= X ^ signMask;
            yReg  <= Y ^ signMask;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!chunkEq || lastChunk) begin
            XlessthanY    <= chunkLt;
            XequalY       <= chunkEq;
            XgreaterthanY <= chunkGt;
            done          <= 1'b1;
            state         <= IDLE;
          end else begin
            xReg <= xReg << CHUNK;
            yReg <= yReg << CHUNK;
            idx  <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy mirrors the RUN state so it falls on the same edge that raises done
  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - directed self-checking bench for the sequential comparator
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] X = '0;
  logic [15:0] Y = '0;
  logic        busy, done, XlessthanY, XequalY, XgreaterthanY;

  logic        start16 = 1'b0;
  logic        signed16 = 1'b0;
  logic [15:0] X16 = '0;
  logic [15:0] Y16 = '0;
  logic        busy16, done16, lt16, eq16, gt16;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .X(X), .Y(Y), .busy(busy), .done(done),
    .XlessthanY(XlessthanY), .XequalY(XequalY), .XgreaterthanY(XgreaterthanY)
  );

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(signed16),
    .X(X16), .Y(Y16), .busy(busy16), .done(done16),
    .XlessthanY(lt16), .XequalY(eq16), .XgreaterthanY(gt16)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {XlessthanY, XequalY, XgreaterthanY};
  endfunction

  // One request; optionally re-pulse start with different operands during RUN
  task automatic runOp(input logic [15:0] x, input logic [15:0] y, input logic sm,
                       input logic disturb, output int lat);
    @(negedge clk);
    X = x; Y = y; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = disturb;
    if (disturb) begin
      X = 16'h0000; Y = 16'hFFFF; signed_mode = 1'b1;
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int lat;
    logic sawDone;

    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_busy", busy, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_flags", flags(), 3'b000);
    checkVal("rst16_flags", {lt16, eq16, gt16}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Equal operands walk all four chunks
    runOp(16'h1234, 16'h1234, 1'b0, 1'b0, lat);
    checkVal("eq_lat", lat, 4);
    checkVal("eq_flags", flags(), 3'b010);

    runOp(16'h9000, 16'h1FFF, 1'b0, 1'b0, lat);
    checkVal("ugt_lat", lat, 1);
    checkVal("ugt_flags", flags(), 3'b001);

    runOp(16'h9000, 16'h1FFF, 1'b1, 1'b0, lat);
    checkVal("slt_lat", lat, 1);
    checkVal("slt_flags", flags(), 3'b100);

    // Third chunk differs
    runOp(16'h1243, 16'h1234, 1'b0, 1'b0, lat);
    checkVal("mid_lat", lat, 3);
    checkVal("mid_flags", flags(), 3'b001);

    runOp(16'h8000, 16'h8000, 1'b1, 1'b0, lat);
    checkVal("seq_lat", lat, 4);
    checkVal("seq_flags", flags(), 3'b010);

    runOp(16'h7FFF, 16'h8000, 1'b1, 1'b0, lat);
    checkVal("sgt_flags", flags(), 3'b001);

    // Extra start and operand changes during RUN must not matter
    runOp(16'h1235, 16'h1234, 1'b0, 1'b1, lat);
    checkVal("dist_lat", lat, 4);
    checkVal("dist_flags", flags(), 3'b001);
    @(posedge clk); #1;
    checkVal("dist_idle", {busy, done}, 2'b00);

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    X = 16'h0001; Y = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("abort_busy", busy, 0);
    checkVal("abort_done", done, 0);
    checkVal("abort_flags", flags(), 3'b000);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      sawDone |= done;
    end
    checkVal("abort_nodone", sawDone, 0);
    checkVal("abort_flags_hold", flags(), 3'b000);

    // Back-to-back: start held through the done cycle
    @(negedge clk);
    X = 16'h9000; Y = 16'h1FFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    X = 16'h0000; Y = 16'hFFFF;
    @(posedge clk); #1;
    checkVal("b2b_done1", done, 1);
    checkVal("b2b_flags1", flags(), 3'b001);
    @(posedge clk); #1;
    checkVal("b2b_gap", {busy, done}, 2'b10);
    checkVal("b2b_hold", flags(), 3'b001);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checkVal("b2b_done2", done, 1);
    checkVal("b2b_flags2", flags(), 3'b100);
    @(posedge clk); #1;
    checkVal("pulse_one", done, 0);

    // Single-chunk instance finishes one edge after start
    @(negedge clk);
    X16 = 16'hFFFF; Y16 = 16'h0000; signed16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); #1;
    checkVal("c16_done", done16, 1);
    checkVal("c16_flags", {lt16, eq16, gt16}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
